// File: rtl/float_op_sched.sv
// Round-robin scheduler that shares one multi-cycle float unit between two requesters.
// One command is in flight at a time; a WAIT-state timeout aborts hung operations with an error response.
module float_op_sched #(
    parameter int NW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          rq0_valid,
    output logic          rq0_ready,
    input  logic [1:0]    rq0_op,
    input  logic [NW-1:0] rq0_a,
    input  logic [NW-1:0] rq0_b,

    input  logic          rq1_valid,
    output logic          rq1_ready,
    input  logic [1:0]    rq1_op,
    input  logic [NW-1:0] rq1_a,
    input  logic [NW-1:0] rq1_b,

    output logic          rs0_valid,
    input  logic          rs0_ready,
    output logic [NW-1:0] rs0_data,
    output logic          rs0_err,

    output logic          rs1_valid,
    input  logic          rs1_ready,
    output logic [NW-1:0] rs1_data,
    output logic          rs1_err,

    output logic          fu_start,
    output logic [1:0]    fu_op,
    output logic [NW-1:0] fu_a,
    output logic [NW-1:0] fu_b,
    input  logic          fu_done,
    input  logic [NW-1:0] fu_res
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]    state;
    logic          owner;
    logic          last_grant;
    logic [7:0]    cnt;
    logic [NW-1:0] rsp_data;
    logic          rsp_err;

    logic          grant;
    logic          accept;
    logic          rsp_taken;

    // On a tie the requester that did not win last time is favoured.
    always_comb begin
        grant = 1'b0;
        if (rq0_valid && rq1_valid) begin
            grant = ~last_grant;
        end else if (rq1_valid) begin
            grant = 1'b1;
        end
    end

    assign accept    = (state == IDLE) && (rq0_valid || rq1_valid);
    assign rq0_ready = accept && !grant;
    assign rq1_ready = accept && grant;

    assign fu_start  = (state == START);

    assign rs0_valid = (state == RESP) && !owner;
    assign rs1_valid = (state == RESP) && owner;
    assign rs0_data  = rsp_data;
    assign rs1_data  = rsp_data;
    assign rs0_err   = rsp_err;
    assign rs1_err   = rsp_err;

    assign rsp_taken = owner ? rs1_ready : rs0_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            fu_op      <= '0;
            fu_a       <= '0;
            fu_b       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= grant;
                        last_grant <= grant;
                        fu_op      <= grant ? rq1_op : rq0_op;
                        fu_a       <= grant ? rq1_a  : rq0_a;
                        fu_b       <= grant ? rq1_b  : rq0_b;
                        state      <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A completion on the final allowed cycle still wins over the abort.
                    if (fu_done) begin
                        rsp_data <= fu_res;
                        rsp_err  <= 1'b0;
                        state    <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_taken) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
